// File: rtl/cpu_pkg.sv
// Types and constants shared by the multicycle CPU control unit and its
// multiply/divide unit.
package cpu_pkg;

  localparam int unsigned MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MULT,
    MD_DIV,
    MD_DONE
  } md_state_t;

  typedef enum logic {
    MD_OP_MULT,
    MD_OP_DIV
  } md_op_t;

endpackage

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring, MIPS
// remainder semantics) producing HI/LO, one step per clock.
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divby0
);

  localparam int unsigned CNT_W = 6;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;     // Booth accumulator / partial remainder
  logic [WIDTH-1:0] q_q, q_d;         // multiplier / quotient bits
  logic             q1_q, q1_d;
  logic [WIDTH:0]   m_q, m_d;         // sign-extended multiplicand / divisor magnitude
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, divby0_q, divby0_d;

  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH+1:0] booth_all, booth_sh;
  logic [WIDTH:0]     rem_sh, div_rem;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   div_quot, abs_a, abs_b;

  // Next-step datapath, next state and registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    q_d        = q_q;
    q1_d       = q1_q;
    m_d        = m_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    divby0_d   = 1'b0;

    abs_a = a[WIDTH-1] ? WIDTH'(-a) : a;
    abs_b = b[WIDTH-1] ? WIDTH'(-b) : b;

    unique case ({q_q[0], q1_q})
      2'b10:   booth_sum = acc_q - m_q;
      2'b01:   booth_sum = acc_q + m_q;
      default: booth_sum = acc_q;
    endcase
    booth_all = {booth_sum, q_q, q1_q};
    booth_sh  = {booth_all[2*WIDTH+1], booth_all[2*WIDTH+1:1]};

    rem_sh = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {1'b0, m_q};
    if (trial[WIDTH+1]) begin
      div_rem  = rem_sh;
      div_quot = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      div_rem  = trial[WIDTH:0];
      div_quot = {q_q[WIDTH-2:0], 1'b1};
    end

    unique case (state_q)
      MD_IDLE: begin
        if (start_mult) begin
          acc_d   = '0;
          q_d     = b;
          q1_d    = 1'b0;
          m_d     = {a[WIDTH-1], a};
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = MD_MULT;
        end else if (start_div) begin
          if (b == '0) begin
            done_d   = 1'b1;
            divby0_d = 1'b1;
            state_d  = MD_DONE;
          end else begin
            acc_d      = '0;
            q_d        = abs_a;
            m_d        = {1'b0, abs_b};
            neg_quot_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_d  = a[WIDTH-1];
            cnt_d      = CNT_W'(WIDTH);
            busy_d     = 1'b1;
            state_d    = MD_DIV;
          end
        end
      end
      MD_MULT: begin
        acc_d = booth_sh[2*WIDTH+1:WIDTH+1];
        q_d   = booth_sh[WIDTH:1];
        q1_d  = booth_sh[0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = booth_sh[2*WIDTH:WIDTH+1];
          lo_d    = booth_sh[WIDTH:1];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = MD_DONE;
        end
      end
      MD_DIV: begin
        acc_d = div_rem;
        q_d   = div_quot;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          lo_d    = neg_quot_q ? WIDTH'(-div_quot) : div_quot;
          hi_d    = neg_rem_q ? WIDTH'(-div_rem[WIDTH-1:0]) : div_rem[WIDTH-1:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = MD_DONE;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      q1_q       <= 1'b0;
      m_q        <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      divby0_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      q1_q       <= q1_d;
      m_q        <= m_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      divby0_q   <= divby0_d;
    end
  end

  assign hi     = hi_q;
  assign lo     = lo_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign divby0 = divby0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: fixed vectors, multicycle corner sequences and
// random operations against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start_mult, start_div;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, divby0;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_hi = '0, prev_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .divby0(divby0)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_mult;
    bit          do_div;
    logic [31:0] a, b, hi, lo;
    bit          dz;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic, SV / and % truncate toward zero.
  task automatic model(input bit is_div, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] ehi, output logic [31:0] elo, output bit edz);
    longint sa, sb, p, qt, rm;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    edz = 1'b0;
    if (!is_div) begin
      p   = sa * sb;
      ehi = p[63:32];
      elo = p[31:0];
    end else if (bv == 32'd0) begin
      edz = 1'b1;
      ehi = prev_hi;
      elo = prev_lo;
    end else begin
      qt  = sa / sb;
      rm  = sa % sb;
      ehi = rm[31:0];
      elo = qt[31:0];
    end
  endtask

  // Drive one operation, watch it to completion, compare. inj>0 pulses a
  // divide-by-zero start at that sample while the op iterates.
  task automatic run_op(input bit dm, input bit dd, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit edz,
                        input int inj, input string tag);
    int lat, bad_busy, bad_hold, exp_lat;
    exp_lat  = edz ? 1 : 33;
    lat      = 0;
    bad_busy = 0;
    bad_hold = 0;
    start_mult = dm; start_div = dd; a = av; b = bv;
    @(negedge clk);
    start_mult = 1'b0; start_div = 1'b0; a = $urandom; b = $urandom;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
      if (hi !== prev_hi || lo !== prev_lo) bad_hold++;
      if (inj != 0 && i == inj) begin
        start_div = 1'b1; b = 32'd0;
      end else if (inj != 0 && i == inj + 1) begin
        start_div = 1'b0;
      end
      @(negedge clk);
    end
    start_div = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".busy_while_iter"}, 32'(bad_busy), 32'd0);
    check({tag, ".hold_while_iter"}, 32'(bad_hold), 32'd0);
    check({tag, ".hi"}, hi, ehi);
    check({tag, ".lo"}, lo, elo);
    check({tag, ".divby0"}, 32'(divby0), 32'(edz));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    prev_hi = ehi;
    prev_lo = elo;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ehi, elo, ra, rb;
    bit edz, isdiv;
    int sel, stray;

    vecs[0]  = '{1, 0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0};
    vecs[1]  = '{0, 1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFEB, 1};
    vecs[2]  = '{1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0};
    vecs[3]  = '{0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0};
    vecs[4]  = '{0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0};
    vecs[5]  = '{0, 1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 0};
    vecs[6]  = '{0, 1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0};
    vecs[7]  = '{1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0};
    vecs[8]  = '{1, 0, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000, 0};
    vecs[9]  = '{0, 1, 32'h80000000, 32'd2,        32'h00000000, 32'hC0000000, 0};
    vecs[10] = '{0, 1, 32'd3,        32'h80000000, 32'h00000003, 32'h00000000, 0};

    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset.hi", hi, 32'd0);
    check("reset.lo", lo, 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.divby0", 32'(divby0), 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].do_mult, vecs[i].do_div, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz, 0, $sformatf("vec%0d", i));

    // Both strobes together: multiply wins
    run_op(1, 1, 32'd3, 32'd4, 32'd0, 32'd12, 0, 0, "both_starts");

    // Divide-by-zero strobe mid-multiply must be ignored
    run_op(1, 0, 32'd5, 32'd6, 32'd0, 32'd30, 0, 10, "start_mid_mult");

    // Reset sampled on the 10th iteration edge aborts without a done pulse
    start_mult = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.hi", hi, 32'd0);
    check("abort.lo", lo, 32'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) stray++;
      @(negedge clk);
    end
    check("abort.no_done", 32'(stray), 32'd0);
    prev_hi = '0;
    prev_lo = '0;
    run_op(1, 0, 32'd2, 32'd3, 32'd0, 32'd6, 0, 0, "after_abort");

    // Random operations against the reference model
    for (int n = 0; n < 30; n++) begin
      isdiv = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) rb = 32'($urandom_range(1, 9));
      else if (sel == 2) ra = 32'h80000000;
      else if (sel == 3) rb = 32'hFFFFFFFF;
      model(isdiv, ra, rb, ehi, elo, edz);
      run_op(!isdiv, isdiv, ra, rb, ehi, elo, edz, 0, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
